// File: rtl/tmds_video_tx.sv
// N-channel DVI transmit core: video timing, valid/ready pixel intake, two-stage TMDS encoder.
// Optional build macro TMDS_TESTPAT_EN adds a test_pat input selecting an internal 8-bar colour source.
module tmds_video_tx #(
    parameter int NCH    = 3,
    parameter int H_ACT  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_ACT  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int HS_POL = 0,
    parameter int VS_POL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef TMDS_TESTPAT_EN
    input  logic              test_pat,
`endif
    input  logic              pix_valid,
    input  logic [8*NCH-1:0]  pix_data,
    output logic              pix_ready,
    output logic              sof,
    output logic              underflow,
    output logic [10*NCH-1:0] tmds,
    output logic [9:0]        tmds_clk
);

    localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int HW = (HT > 2) ? $clog2(HT) : 1;
    localparam int VW = (VT > 2) ? $clog2(VT) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(HT - 1);
    localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
    localparam logic [HW-1:0] HS_START = HW'(H_ACT + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(VT - 1);
    localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACT);
    localparam logic [VW-1:0] VS_START = VW'(V_ACT + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACT + V_FP + V_SYNC);

    // Idle sync level: with active-low polarity the line rests high.
    localparam logic HS_IDLE = (HS_POL == 0);
    localparam logic VS_IDLE = (VS_POL == 0);

    localparam logic [9:0] TOK_00 = 10'b1101010100;
    localparam logic [9:0] TOK_01 = 10'b0010101011;
    localparam logic [9:0] TOK_10 = 10'b0101010100;
    localparam logic [9:0] TOK_11 = 10'b1010101011;

    logic [HW-1:0]    h;
    logic [VW-1:0]    v;
    logic             active;
    logic             hs_level;
    logic             vs_level;
    logic             src_ok;
    logic             ext_src;
    logic [8*NCH-1:0] src_data;
    logic [8*NCH-1:0] s1_data;

    logic [8:0]       qm_s1 [NCH];
    logic             de_s1;
    logic [1:0]       ctrl0_s1;

    assign active   = (h < H_ACT_C) && (v < V_ACT_C);
    assign hs_level = ((h >= HS_START) && (h < HS_END)) ^ HS_IDLE;
    assign vs_level = ((v >= VS_START) && (v < VS_END)) ^ VS_IDLE;

`ifdef TMDS_TESTPAT_EN
    logic [2:0]       bar;
    logic [NCH-1:0]   bar_bits;
    logic [8*NCH-1:0] pat_data;

    always_comb begin
        bar      = 3'((int'(h) * 8) / H_ACT);
        bar_bits = NCH'(bar);
        pat_data = '0;
        for (int k = 0; k < NCH; k++) begin
            pat_data[8*k +: 8] = {8{bar_bits[k]}};
        end
    end

    assign src_data = test_pat ? pat_data : pix_data;
    assign src_ok   = test_pat | pix_valid;
    assign ext_src  = ~test_pat;
`else
    assign src_data = pix_data;
    assign src_ok   = pix_valid;
    assign ext_src  = 1'b1;
`endif

    // Handshake flags are held low while reset is asserted, even though h=v=0 then.
    assign pix_ready = rst & en & active & ext_src;
    assign underflow = rst & en & active & ~src_ok;
    assign sof       = rst & en & (h == '0) & (v == '0);
    assign s1_data   = (en && active && src_ok) ? src_data : '0;
    assign tmds_clk  = 10'b0000011111;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h <= '0;
            v <= '0;
        end else if (en) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    function automatic logic [8:0] minimise(input logic [7:0] d);
        int   n1;
        logic use_xnor;
        logic [8:0] q;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 = n1 + int'(d[i]);
        use_xnor = (n1 > 4) || ((n1 == 4) && !d[0]);
        q    = '0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Disabled cycles enter the pipeline as blanking with idle syncs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            de_s1    <= 1'b0;
            ctrl0_s1 <= 2'b00;
            for (int k = 0; k < NCH; k++) qm_s1[k] <= '0;
        end else begin
            de_s1    <= en && active;
            ctrl0_s1 <= en ? {vs_level, hs_level} : {VS_IDLE, HS_IDLE};
            for (int k = 0; k < NCH; k++) qm_s1[k] <= minimise(s1_data[8*k +: 8]);
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic signed [4:0] cnt;
        logic signed [4:0] cnt_next;
        logic [9:0]        word;
        logic [9:0]        word_next;
        logic [1:0]        ctrl;

        assign ctrl = (k == 0) ? ctrl0_s1 : 2'b00;

        always_comb begin
            logic [8:0] q;
            int         n1;
            int         disp;
            int         c;
            q         = qm_s1[k];
            n1        = 0;
            for (int i = 0; i < 8; i++) n1 = n1 + int'(q[i]);
            disp      = 2 * n1 - 8;
            c         = int'(cnt);
            word_next = TOK_00;
            cnt_next  = '0;
            if (!de_s1) begin
                case (ctrl)
                    2'b01:   word_next = TOK_01;
                    2'b10:   word_next = TOK_10;
                    2'b11:   word_next = TOK_11;
                    default: word_next = TOK_00;
                endcase
            end else if ((c == 0) || (disp == 0)) begin
                word_next = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
                cnt_next  = 5'(q[8] ? c + disp : c - disp);
            end else if (((c > 0) && (disp > 0)) || ((c < 0) && (disp < 0))) begin
                word_next = {1'b1, q[8], ~q[7:0]};
                cnt_next  = 5'(c + 2 * int'(q[8]) - disp);
            end else begin
                word_next = {1'b0, q[8], q[7:0]};
                cnt_next  = 5'(c - 2 * int'(!q[8]) + disp);
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                word <= TOK_00;
                cnt  <= '0;
            end else begin
                word <= word_next;
                cnt  <= cnt_next;
            end
        end

        assign tmds[10*k +: 10] = word;
    end

endmodule
